// File: rtl/poly_operand_driver_pkg.sv
// Shared definitions for the polynomial evaluator operand driver:
// FSM states, operand index constants and default timing values.
package poly_operand_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PRESS,
    ST_RELEASE,
    ST_SETTLE,
    ST_DONE
  } drv_state_t;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_X = 2'd3;

  localparam int unsigned DEF_HOLD_CYCLES   = 2;
  localparam int unsigned DEF_GAP_CYCLES    = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 8;

endpackage

// File: rtl/poly_operand_driver_if.sv
// Evaluator-facing operand bus: the driver is master, the evaluator is slave.
interface poly_operand_driver_if;
  logic [7:0] data_out;
  logic       go;
  logic [7:0] result_in;

  modport master (output data_out, go, input result_in);
  modport slave  (input data_out, go, output result_in);
endinterface

// File: rtl/poly_operand_driver_timer.sv
// Loadable 8-bit down-counter timing the PRESS, RELEASE and SETTLE phases.
module poly_driver_timer (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 8'd1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/poly_operand_driver.sv
// Automatic operand-load initiator for the Ax^2+Bx+C evaluator: presents
// A, B, C, X with a press/release go handshake, then captures the result.
module poly_operand_driver
  import poly_operand_driver_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [7:0]             coef_a,
  input  logic [7:0]             coef_b,
  input  logic [7:0]             coef_c,
  input  logic [7:0]             x_in,
  poly_operand_driver_if.master  eval_bus,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             result
);

  // The timer is loaded with N-1 on entry so each timed state lasts N cycles.
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD    = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  drv_state_t state, state_nx;
  logic [1:0] idx;
  logic [7:0] ops [4];

  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_expired;
  logic       accept;
  logic       idx_inc;
  logic       capture;
  logic       drive;
  logic       go_int;

  poly_driver_timer u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      idx    <= IDX_A;
      result <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        ops[i] <= '0;
      end
    end else begin
      state <= state_nx;
      if (accept) begin
        ops[IDX_A] <= coef_a;
        ops[IDX_B] <= coef_b;
        ops[IDX_C] <= coef_c;
        ops[IDX_X] <= x_in;
        idx        <= IDX_A;
      end else if (idx_inc) begin
        idx <= idx + 2'd1;
      end
      if (capture) begin
        result <= eval_bus.result_in;
      end
    end
  end

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    idx_inc  = 1'b0;
    capture  = 1'b0;
    drive    = 1'b0;
    go_int   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = ST_SETUP;
        end
      end
      ST_SETUP: begin
        busy     = 1'b1;
        drive    = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = HOLD_LOAD;
        state_nx = ST_PRESS;
      end
      ST_PRESS: begin
        busy   = 1'b1;
        drive  = 1'b1;
        go_int = 1'b1;
        if (tmr_expired) begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_nx = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        busy  = 1'b1;
        drive = 1'b1;
        if (tmr_expired) begin
          if (idx != IDX_X) begin
            idx_inc  = 1'b1;
            state_nx = ST_SETUP;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
            state_nx = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        busy  = 1'b1;
        drive = 1'b1;
        if (tmr_expired) begin
          capture  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign eval_bus.data_out = drive ? ops[idx] : '0;
  assign eval_bus.go       = go_int;

endmodule
